// File: rtl/sreg_link.sv
// Free-running serial link to an external 74HC595/74HC165-style chain.
// Each frame loads a parallel word, shifts it out MSB first while capturing sdi, then strobes lock.
module sreg_link #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 18
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_old,
    output logic             sclk,
    output logic             sdo,
    output logic             lock,
    input  logic             sdi,
    output logic             frame_done,
    output logic             busy
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PW-1:0] PCNT_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PCNT_RISE = PW'(CLK_DIV / 2 - 1);
    localparam logic [PW-1:0] PCNT_HALF = PW'(CLK_DIV / 2);
    localparam logic [PW-1:0] PCNT_ONE  = PW'(1);
    localparam logic [BW-1:0] BCNT_TOP  = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BCNT_ONE  = BW'(1);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] txsh_q, txsh_d;
    logic [WIDTH-1:0] rxsh_q, rxsh_d;
    logic [WIDTH-1:0] data_old_q, data_old_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;
    logic             lock_q, lock_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             pcnt_wrap;
    logic [WIDTH-1:0] tx_next;
    logic [WIDTH-1:0] rx_next;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q      <= ST_LOAD;
            pcnt_q       <= '0;
            bcnt_q       <= BCNT_TOP;
            txsh_q       <= '0;
            rxsh_q       <= '0;
            data_old_q   <= '0;
            sclk_q       <= 1'b0;
            sdo_q        <= 1'b0;
            lock_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            bcnt_q       <= bcnt_d;
            txsh_q       <= txsh_d;
            rxsh_q       <= rxsh_d;
            data_old_q   <= data_old_d;
            sclk_q       <= sclk_d;
            sdo_q        <= sdo_d;
            lock_q       <= lock_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        bcnt_d       = bcnt_q;
        txsh_d       = txsh_q;
        rxsh_d       = rxsh_q;
        data_old_d   = data_old_q;
        sclk_d       = sclk_q;
        sdo_d        = sdo_q;
        lock_d       = lock_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        pcnt_wrap = (pcnt_q == PCNT_LAST);
        // Shift helpers written without part-selects so WIDTH=1 collapses cleanly.
        tx_next   = txsh_q << 1;
        rx_next   = (rxsh_q << 1) | WIDTH'(sdi);

        case (state_q)
            ST_LOAD: begin
                txsh_d  = data;
                pcnt_d  = '0;
                bcnt_d  = BCNT_TOP;
                sdo_d   = data[WIDTH-1];
                sclk_d  = 1'b0;
                lock_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = ST_SHIFT;
            end

            ST_SHIFT: begin
                pcnt_d = pcnt_wrap ? '0 : pcnt_q + PCNT_ONE;
                sclk_d = (pcnt_d >= PCNT_HALF);
                // sdi is captured on the same clk that drives sclk high.
                if (pcnt_q == PCNT_RISE) begin
                    rxsh_d = rx_next;
                end
                if (pcnt_wrap) begin
                    if (bcnt_q == '0) begin
                        lock_d  = 1'b1;
                        state_d = ST_LATCH;
                    end else begin
                        bcnt_d = bcnt_q - BCNT_ONE;
                        txsh_d = tx_next;
                        sdo_d  = tx_next[WIDTH-1];
                    end
                end
            end

            ST_LATCH: begin
                pcnt_d = pcnt_wrap ? '0 : pcnt_q + PCNT_ONE;
                sclk_d = 1'b0;
                if (pcnt_wrap) begin
                    data_old_d   = rxsh_q;
                    frame_done_d = 1'b1;
                    lock_d       = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign data_old   = data_old_q;
    assign sclk       = sclk_q;
    assign sdo        = sdo_q;
    assign lock       = lock_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sreg_link.sv
// Bench for sreg_link: a frame-timeline reference model checks every output each cycle,
// with table-driven frames, a loopback chain, random sdi, mid-frame abort and a 24x4 instance.
module tb_sreg_link;

    localparam int W   = 16;
    localparam int CD  = 18;
    localparam int H   = CD / 2;
    localparam int P   = 1 + (W + 1) * CD;
    localparam int W2  = 24;
    localparam int CD2 = 4;
    localparam int P2  = 1 + (W2 + 1) * CD2;
    localparam int NT  = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          sclr = 1'b1;
    logic [W-1:0]  data = '0;
    logic [W-1:0]  data_old;
    logic          sclk, sdo, lock, frame_done, busy;
    logic          sdi;

    logic          sclr2 = 1'b1;
    logic [W2-1:0] data2 = '0;
    logic [W2-1:0] data_old2;
    logic          sclk2, sdo2, lock2, frame_done2, busy2;
    logic          sdi2;

    logic [1:0]    sdi_mode = 2'd0;
    logic [W-1:0]  sdi_word = '0;
    logic          sdi_drv  = 1'b0;
    logic          sdi_pre  = 1'b0;
    logic [W-1:0]  chain    = 16'hA5C3;
    logic          sclk_prev = 1'b0;
    logic [W-1:0]  sdo_cap  = '0;

    assign sdi  = (sdi_mode == 2'd3) ? chain[W-1] : sdi_drv;
    assign sdi2 = sdo2;

    sreg_link #(.WIDTH(W), .CLK_DIV(CD)) dut (
        .clk(clk), .sclr(sclr), .data(data), .data_old(data_old), .sclk(sclk),
        .sdo(sdo), .lock(lock), .sdi(sdi), .frame_done(frame_done), .busy(busy)
    );

    sreg_link #(.WIDTH(W2), .CLK_DIV(CD2)) dut2 (
        .clk(clk), .sclr(sclr2), .data(data2), .data_old(data_old2), .sclk(sclk2),
        .sdo(sdo2), .lock(lock2), .sdi(sdi2), .frame_done(frame_done2), .busy(busy2)
    );

    // Reference model: position in the frame follows from clks since reset.
    int           k = 0;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_word = '0;
    logic [W-1:0] m_rx   = '0;
    logic [W-1:0] m_old  = '0;

    always @(posedge clk) begin
        int p;
        if (sclr) begin
            k     = 0;
            m_rx  = '0;
            m_old = '0;
        end else begin
            k = k + 1;
            p = (k - 1) % P;
            if (p == 0) m_word = data;
            if (p < W * CD && (p % CD) == H) m_rx[W-1-p/CD] = sdi_pre;
            if (p == (W + 1) * CD) m_old = m_rx;
        end
        m_valid = 1'b1;
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    int            cnt2  = 0;
    int            fd2_n = 0;
    bit            fd2_prev = 1'b0;
    logic [W2-1:0] exp2 = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        int   p;
        logic e_sclk, e_sdo, e_lock, e_busy, e_fd;
        @(negedge clk);
        p = (k > 0) ? (k - 1) % P : 0;
        if (m_valid) begin
            if (k == 0) begin
                {e_sclk, e_sdo, e_lock, e_busy, e_fd} = 5'b0;
            end else if (p < W * CD) begin
                e_sclk = ((p % CD) >= H);
                e_sdo  = m_word[W-1-p/CD];
                e_lock = 1'b0; e_busy = 1'b1; e_fd = 1'b0;
            end else if (p < (W + 1) * CD) begin
                e_sclk = 1'b0; e_sdo = m_word[0];
                e_lock = 1'b1; e_busy = 1'b1; e_fd = 1'b0;
            end else begin
                e_sclk = 1'b0; e_sdo = m_word[0];
                e_lock = 1'b0; e_busy = 1'b0; e_fd = 1'b1;
            end
            check("cyc_sclk", 64'(sclk), 64'(e_sclk));
            check("cyc_sdo", 64'(sdo), 64'(e_sdo));
            check("cyc_lock", 64'(lock), 64'(e_lock));
            check("cyc_busy", 64'(busy), 64'(e_busy));
            check("cyc_frame_done", 64'(frame_done), 64'(e_fd));
            check("cyc_data_old", 64'(data_old), 64'(m_old));
        end
        if (k > 0) begin
            if (p == 0) sdo_cap = '0;
            if (p < W * CD && (p % CD) == H) sdo_cap = {sdo_cap[W-2:0], sdo};
        end
        // External chain shifts on each sclk rise.
        if (sdi_mode != 2'd3) chain = 16'hA5C3;
        else if (sclk === 1'b1 && sclk_prev == 1'b0) chain = {chain[W-2:0], sdo};
        sclk_prev = (sclk === 1'b1);
        case (sdi_mode)
            2'd0: sdi_drv = 1'($urandom);
            2'd1: sdi_drv = (k > 0 && p < W * CD) ? sdi_word[W-1-p/CD] : 1'b0;
            2'd2: if (k > 0 && p < W * CD && (p % CD) >= H) sdi_drv = 1'($urandom);
            default: sdi_drv = 1'b0;
        endcase
        sdi_pre = (sdi_mode == 2'd3) ? chain[W-1] : sdi_drv;
        if (!sclr2) cnt2++;
        if (fd2_prev) check("fd2_width", 64'(frame_done2), 64'd0);
        if (frame_done2 === 1'b1) begin
            fd2_n++;
            check("period_24x4", 64'(cnt2), 64'(P2));
            check("data_old_24x4", 64'(data_old2), 64'(exp2));
            cnt2  = 0;
            data2 = W2'($urandom);
            exp2  = data2;
        end
        fd2_prev = (frame_done2 === 1'b1);
    endtask

    task automatic run_frame(input logic [W-1:0] mid, input bit chk_load, output int cyc);
        cyc = 0;
        for (int c = 1; c <= P + 20; c++) begin
            tick();
            if (c == 1 && chk_load) begin
                check("load_busy", 64'(busy), 64'd1);
                check("load_sdo", 64'(sdo), 64'(data[W-1]));
            end
            if (c == 100) data = mid;
            if (frame_done === 1'b1) begin
                cyc = c;
                return;
            end
        end
        check("frame_timeout", 64'(frame_done), 64'd1);
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] mid;
        logic [W-1:0] sdi_word;
        logic [W-1:0] exp_old;
        logic [W-1:0] exp_sdo;
    } vec_t;

    vec_t         tv[NT];
    int           cyc;
    logic [W-1:0] sent;

    initial begin
        tv[0] = '{16'h0824, 16'h0824, 16'hA5C3, 16'hA5C3, 16'h0824};
        tv[1] = '{16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h1111};
        tv[2] = '{16'h2222, 16'h2222, 16'hFFFF, 16'hFFFF, 16'h2222};
        tv[3] = '{16'hFFFF, 16'h0000, 16'h8001, 16'h8001, 16'hFFFF};
        tv[4] = '{16'h0001, 16'h0001, 16'h1234, 16'h1234, 16'h0001};
        tv[5] = '{16'h8000, 16'h7FFF, 16'h7FFE, 16'h7FFE, 16'h8000};

        data2 = W2'($urandom);
        exp2  = data2;
        repeat (3) tick();
        check("rst_sclk", 64'(sclk), 64'd0);
        check("rst_sdo", 64'(sdo), 64'd0);
        check("rst_lock", 64'(lock), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_data_old", 64'(data_old), 64'd0);

        for (int i = 0; i < NT; i++) begin
            data     = tv[i].data;
            sdi_word = tv[i].sdi_word;
            sdi_mode = 2'd1;
            if (i == 0) begin
                sclr  = 1'b0;
                sclr2 = 1'b0;
            end
            run_frame(tv[i].mid, (i == 0), cyc);
            check("tbl_period", 64'(cyc), 64'(P));
            check("tbl_data_old", 64'(data_old), 64'(tv[i].exp_old));
            check("tbl_sdo_word", 64'(sdo_cap), 64'(tv[i].exp_sdo));
        end

        sdi_mode = 2'd3;
        data     = 16'h0824;
        run_frame(16'h0824, 1'b0, cyc);
        check("loop1_data_old", 64'(data_old), 64'hA5C3);
        run_frame(16'h0824, 1'b0, cyc);
        check("loop2_data_old", 64'(data_old), 64'h0824);

        for (int i = 0; i < 6; i++) begin
            sdi_mode = (i < 3) ? 2'd0 : 2'd2;
            data     = W'($urandom);
            sent     = data;
            run_frame(W'($urandom), 1'b0, cyc);
            check("rand_period", 64'(cyc), 64'(P));
            check("rand_data_old", 64'(data_old), 64'(m_old));
            check("rand_sdo_word", 64'(sdo_cap), 64'(sent));
        end

        data = 16'hBEEF;
        repeat (50) tick();
        sclr = 1'b1;
        tick();
        check("abort_sclk", 64'(sclk), 64'd0);
        check("abort_sdo", 64'(sdo), 64'd0);
        check("abort_lock", 64'(lock), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_data_old", 64'(data_old), 64'd0);
        repeat (2) begin
            tick();
            check("abort_frame_done", 64'(frame_done), 64'd0);
        end
        sclr     = 1'b0;
        sdi_mode = 2'd0;
        data     = 16'hC3A5;
        run_frame(16'hC3A5, 1'b1, cyc);
        check("abort_period", 64'(cyc), 64'(P));
        check("abort_new_data_old", 64'(data_old), 64'(m_old));

        check("fd2_seen", 64'(fd2_n >= 30), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $fatal(1);
    end

endmodule
